// File: rtl/tetris_pkg.sv
// tetris_pkg: shared types and constants for the Tetris board engines.
//   ROW_IDX_W     : width of every board row index (mux32/demux32 selects)
//   lcs_state_t   : line_clear_scanner FSM states
//   LCS_W/LCS_ROWS: default board geometry
//   LCS_FULL_ROW  : all-ones mask of a completely filled default-width row
package tetris_pkg;

    localparam int ROW_IDX_W = 5;
    localparam int LCS_W     = 10;
    localparam int LCS_ROWS  = 20;

    localparam logic [LCS_W-1:0] LCS_FULL_ROW = {LCS_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } lcs_state_t;

endpackage

// File: rtl/line_clear_scanner_row_counter.sv
// row_counter: loadable down-counter with zero flag.
//   clock, reset : rising-edge clock, async active-high reset (count -> 0)
//   load/load_val: synchronous load, has priority over dec
//   dec          : decrement by one
//   count, zero  : current value and (count == 0)
module row_counter
    import tetris_pkg::*;
#(
    parameter int WIDTH = ROW_IDX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec)
            count <= count - WIDTH'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/line_clear_scanner.sv
// line_clear_scanner: scans the board bottom-to-top on start, removes every
// full row by copying each row above it down one, and inserts a zero row at
// the top. Reports how many rows were cleared.
//   clock, reset   : rising-edge clock, async active-high reset
//   start          : one-cycle pulse, honoured only when idle
//   row_sel/row_data : read port to the board mux (row_data is combinational)
//   wr_en/wr_sel/wr_data : board write port
//   busy, done     : scan in progress / one-cycle end pulse
//   lines_cleared  : rows cleared by the last scan, held until next start
module line_clear_scanner
    import tetris_pkg::*;
#(
    parameter int W    = LCS_W,
    parameter int ROWS = LCS_ROWS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    output logic [ROW_IDX_W-1:0] row_sel,
    input  logic [W-1:0]         row_data,
    output logic                 wr_en,
    output logic [ROW_IDX_W-1:0] wr_sel,
    output logic [W-1:0]         wr_data,
    output logic                 busy,
    output logic                 done,
    output logic [5:0]           lines_cleared
);

    localparam logic [W-1:0] FULL_ROW = {W{1'b1}};
    localparam logic [ROW_IDX_W-1:0] BOTTOM = ROW_IDX_W'(ROWS - 1);

    lcs_state_t state, state_nx;

    logic [ROW_IDX_W-1:0] cur, src;
    logic                 cur_zero, src_zero;
    logic                 cur_load, cur_dec, src_load, src_dec;
    logic                 row_full;

    assign row_full = (row_data == FULL_ROW);

    row_counter #(.WIDTH(ROW_IDX_W)) u_cur (
        .clock    (clock),
        .reset    (reset),
        .load     (cur_load),
        .load_val (BOTTOM),
        .dec      (cur_dec),
        .count    (cur),
        .zero     (cur_zero)
    );

    // src is loaded from cur when a full row is found; it then walks up
    // the board one row per SHIFT cycle.
    row_counter #(.WIDTH(ROW_IDX_W)) u_src (
        .clock    (clock),
        .reset    (reset),
        .load     (src_load),
        .load_val (cur),
        .dec      (src_dec),
        .count    (src),
        .zero     (src_zero)
    );

    always_comb begin
        state_nx = state;
        cur_load = 1'b0;
        cur_dec  = 1'b0;
        src_load = 1'b0;
        src_dec  = 1'b0;
        unique case (state)
            IDLE: if (start) begin
                cur_load = 1'b1;
                state_nx = SCAN;
            end
            SCAN: if (row_full) begin
                src_load = 1'b1;
                state_nx = SHIFT;
            end else if (cur_zero) begin
                state_nx = DONE;
            end else begin
                cur_dec = 1'b1;
            end
            // cur is left alone: the scanned index now holds the row that
            // was above it and must be checked again.
            SHIFT: if (src_zero) state_nx = SCAN;
                   else          src_dec  = 1'b1;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            lines_cleared <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start)
                lines_cleared <= '0;
            else if (state == SCAN && row_full)
                lines_cleared <= lines_cleared + 6'd1;
        end
    end

    // Outputs decode from registered state only; row_data -> wr_data is the
    // single combinational input-to-output path.
    always_comb begin
        row_sel = '0;
        wr_en   = 1'b0;
        wr_sel  = '0;
        wr_data = '0;
        if (state == SCAN) begin
            row_sel = cur;
        end else if (state == SHIFT) begin
            wr_en  = 1'b1;
            wr_sel = src;
            if (!src_zero) begin
                row_sel = src - ROW_IDX_W'(1);
                wr_data = row_data;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
